// File: rtl/twos_bcd_decoder_pkg.sv
// rtl/twos_bcd_decoder_pkg.sv - shared types and constants for the two's-complement to BCD decoder
package twos_bcd_decoder_pkg;
  localparam int W_DEF    = 16;
  localparam int NDIG_DEF = 5;
  localparam int DIG_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/twos_bcd_decoder_if.sv
// rtl/twos_bcd_decoder_if.sv - start/busy/done conversion handshake bundle
interface twos_bcd_decoder_if
  import twos_bcd_decoder_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NDIG = NDIG_DEF
);
  logic                    start;
  logic [W-1:0]            din;
  logic                    busy;
  logic                    done;
  logic                    neg;
  logic [DIG_W*NDIG-1:0]   bcd;

  modport master (output start, output din, input busy, input done, input neg, input bcd);
  modport slave  (input start, input din, output busy, output done, output neg, output bcd);
endinterface

// File: rtl/twos_bcd_decoder_bcd_add3.sv
// rtl/twos_bcd_decoder_bcd_add3.sv - double-dabble digit correction cell (add 3 when digit >= 5)
module bcd_add3
  import twos_bcd_decoder_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adj
);
  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

// File: rtl/twos_bcd_decoder.sv
// rtl/twos_bcd_decoder.sv - sequential sign + BCD magnitude decoder for two's-complement results
module twos_bcd_decoder
  import twos_bcd_decoder_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  twos_bcd_decoder_if.slave  bus
);
  localparam int CNT_W = $clog2(W + 1);
  localparam int BCD_W = DIG_W * NDIG;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [W-1:0]       mag, mag_n;
  logic [BCD_W-1:0]   dig, dig_n, dig_adj;
  logic [BCD_W-1:0]   bcd_q, bcd_n;
  logic               neg_q, neg_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;

  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_add3
      bcd_add3 u_add3 (
        .digit (dig[i*DIG_W +: DIG_W]),
        .adj   (dig_adj[i*DIG_W +: DIG_W])
      );
    end
  endgenerate

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mag_n   = mag;
    dig_n   = dig;
    bcd_n   = bcd_q;
    neg_n   = neg_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          // W-bit negation is exact even for the most-negative value
          neg_n   = bus.din[W-1];
          mag_n   = bus.din[W-1] ? (~bus.din + {{(W-1){1'b0}}, 1'b1}) : bus.din;
          dig_n   = '0;
          cnt_n   = CNT_W'(W);
          state_n = SHIFT;
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        {dig_n, mag_n} = {dig_adj, mag} << 1;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE: begin
        bcd_n   = dig;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mag    <= '0;
      dig    <= '0;
      bcd_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mag    <= mag_n;
      dig    <= dig_n;
      bcd_q  <= bcd_n;
      neg_q  <= neg_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_twos_bcd_decoder.sv
// tb/tb_twos_bcd_decoder.sv - self-checking bench for twos_bcd_decoder
module tb_twos_bcd_decoder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  twos_bcd_decoder_if #(.W(16), .NDIG(5)) bus ();

  twos_bcd_decoder #(.W(16), .NDIG(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] din;
    logic        exp_neg;
    logic [19:0] exp_bcd;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] hist[72];
  logic [15:0] rv;
  int          n;
  int          ndone;
  bit          seen;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    int          m;
    logic [19:0] r;
    m = $signed(v);
    if (m < 0) m = -m;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_neg(input logic [15:0] v);
    return $signed(v) < 0;
  endfunction

  task automatic run_conv(input string name, input logic [15:0] v,
                          input logic en, input logic [19:0] eb);
    int lat;
    bit got;
    bus.din   = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      step();
      lat++;
      if (bus.done) got = 1'b1;
    end
    chk({name, "_lat"}, 32'(lat), 32'd17);
    chk({name, "_neg"}, 32'(bus.neg), 32'(en));
    chk({name, "_bcd"}, 32'(bus.bcd), 32'(eb));
    step();
    chk({name, "_done_low"}, 32'(bus.done), 32'd0);
    chk({name, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{"zero",   16'h0000, 1'b0, 20'h00000};
    vecs[1] = '{"maxpos", 16'h7FFF, 1'b0, 20'h32767};
    vecs[2] = '{"maxneg", 16'h8000, 1'b1, 20'h32768};
    vecs[3] = '{"m1",     16'hFFFF, 1'b1, 20'h00001};
    vecs[4] = '{"aaaa",   16'hAAAA, 1'b1, 20'h21846};
    vecs[5] = '{"aaa9",   16'hAAA9, 1'b1, 20'h21847};
    vecs[6] = '{"aaab",   16'hAAAB, 1'b1, 20'h21845};
    vecs[7] = '{"p42",    16'h0042, 1'b0, 20'h00066};
    vecs[8] = '{"p9999",  16'h270F, 1'b0, 20'h09999};

    bus.start = 1'b0;
    bus.din   = '0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_neg",  32'(bus.neg),  32'd0);
    chk("rst_bcd",  32'(bus.bcd),  32'd0);

    for (int i = 0; i < 9; i++)
      run_conv(vecs[i].name, vecs[i].din, vecs[i].exp_neg, vecs[i].exp_bcd);

    for (int i = 0; i < 25; i++) begin
      rv = 16'($urandom);
      run_conv("rand", rv, ref_neg(rv), ref_bcd(rv));
    end

    // start held high: captures every 18 cycles, DONE-cycle start ignored
    bus.start = 1'b1;
    for (int c = 0; c < 72; c++) begin
      rv      = 16'($urandom);
      hist[c] = rv;
      bus.din = rv;
      step();
      if (c % 18 == 17) begin
        chk("hs_done", 32'(bus.done), 32'd1);
        chk("hs_bcd",  32'(bus.bcd), 32'(ref_bcd(hist[c-17])));
        chk("hs_neg",  32'(bus.neg), 32'(ref_neg(hist[c-17])));
      end else begin
        chk("hs_nodone", 32'(bus.done), 32'd0);
      end
    end
    bus.start = 1'b0;
    step();
    chk("hs_busy_end", 32'(bus.busy), 32'd0);

    // start while busy must not redirect or queue a conversion
    bus.din   = 16'h0123;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.din   = 16'h7000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.din   = 16'h0000;
    n = 5;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk("ign_lat", 32'(n), 32'd17);
    chk("ign_bcd", 32'(bus.bcd), 32'h00291);
    repeat (4) step();
    chk("ign_busy", 32'(bus.busy), 32'd0);
    chk("ign_done", 32'(bus.done), 32'd0);

    // reset mid-conversion
    run_conv("pre_rst", 16'hFFFF, 1'b1, 20'h00001);
    bus.din   = 16'h1234;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_neg",  32'(bus.neg),  32'd0);
    chk("mid_rst_bcd",  32'(bus.bcd),  32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    run_conv("post_rst", 16'h0042, 1'b0, 20'h00066);

    // outputs hold while idle
    run_conv("hold_conv", 16'h0064, 1'b0, 20'h00100);
    for (int c = 0; c < 50; c++) begin
      bus.din = (c % 2 == 0) ? 16'hFFFF : 16'h1357;
      step();
      chk("hold_bcd",  32'(bus.bcd),  32'h00100);
      chk("hold_neg",  32'(bus.neg),  32'd0);
      chk("hold_done", 32'(bus.done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
